// File: rtl/matrix_ops_pkg.sv
// Shared types and helpers for the matrix_ops datapath.
// Holds the FSM state encoding and the element bit-offset helper.
package matrix_ops_pkg;

    // Three-state sequencer for element-serial matrix operations
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit offset of element k in a packed matrix of w-bit elements
    function automatic int elem_offset(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/matrix_sum.sv
// Element-wise adder for two MxN matrices, one element per clock.
// Ports: i_clk, i_rst_n (async low), i_calc_cmd (level start),
//   i_matrix_a/i_matrix_b (packed operands), o_matrix (packed sum),
//   o_ready (result valid).
module matrix_sum
    import matrix_ops_pkg::*;
#(
    parameter int MATRIX_SIZE_M = 3,
    parameter int MATRIX_SIZE_N = 2,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_calc_cmd,
    input  logic [MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] i_matrix_a,
    input  logic [MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] i_matrix_b,
    output logic [MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] o_matrix,
    output logic                                          o_ready
);

    localparam int ELEMS      = MATRIX_SIZE_M * MATRIX_SIZE_N;
    localparam int SIZE_BLOCK = ELEMS * DATA_WIDTH;
    localparam int IDX_W      = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ELEMS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SIZE_BLOCK-1:0]   a_q, a_d;
    logic [SIZE_BLOCK-1:0]   b_q, b_d;
    logic [SIZE_BLOCK-1:0]   res_q, res_d;
    logic [SIZE_BLOCK-1:0]   out_q, out_d;
    logic                    ready_q, ready_d;

    // Result vector with the current element's sum merged in
    logic [SIZE_BLOCK-1:0]   res_wr;
    logic [DATA_WIDTH-1:0]   sum_w [ELEMS];

    // Carry out of each element add is dropped (mod 2^W)
    for (genvar k = 0; k < ELEMS; k++) begin : g_sum
        assign sum_w[k] =
            a_q[elem_offset(k, DATA_WIDTH) +: DATA_WIDTH]
          + b_q[elem_offset(k, DATA_WIDTH) +: DATA_WIDTH];
    end

    always_comb begin
        res_wr = res_q;
        for (int k = 0; k < ELEMS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                res_wr[k*DATA_WIDTH +: DATA_WIDTH] = sum_w[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        out_d   = out_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (i_calc_cmd) begin
                    a_d     = i_matrix_a;
                    b_d     = i_matrix_b;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d = res_wr;
                if (idx_q == LAST) begin
                    // Publish only the completed matrix
                    out_d   = res_wr;
                    ready_d = 1'b1;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Stay here until the command drops: no auto-restart
                if (!i_calc_cmd) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign o_matrix = out_q;
    assign o_ready  = ready_q;

endmodule

// File: tb/tb_matrix_sum.sv
// Scoreboard bench for matrix_sum: default 3x2x16 instance plus
// 1x1x16 and 4x3x8 instances for the parameter sweep.
module tb_matrix_sum;

    typedef struct {
        logic [95:0] data;
        int          start;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          checks;
    int          errors;

    logic        cmd0, cmd1, cmd2;
    logic [95:0] a0, b0, mat0;
    logic [15:0] a1, b1, mat1;
    logic [95:0] a2, b2, mat2;
    logic        rdy0, rdy1, rdy2;
    logic        prev0, prev1, prev2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    matrix_sum #(
        .MATRIX_SIZE_M(3), .MATRIX_SIZE_N(2), .DATA_WIDTH(16)
    ) d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_calc_cmd(cmd0),
        .i_matrix_a(a0), .i_matrix_b(b0),
        .o_matrix(mat0), .o_ready(rdy0)
    );

    matrix_sum #(
        .MATRIX_SIZE_M(1), .MATRIX_SIZE_N(1), .DATA_WIDTH(16)
    ) d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_calc_cmd(cmd1),
        .i_matrix_a(a1), .i_matrix_b(b1),
        .o_matrix(mat1), .o_ready(rdy1)
    );

    matrix_sum #(
        .MATRIX_SIZE_M(4), .MATRIX_SIZE_N(3), .DATA_WIDTH(8)
    ) d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_calc_cmd(cmd2),
        .i_matrix_a(a2), .i_matrix_b(b2),
        .o_matrix(mat2), .o_ready(rdy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitors: pop one expectation per rising o_ready
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rdy0 && !prev0) begin
            if (q0.size() == 0) begin
                fail_note("d0_spurious_ready");
            end else begin
                e = q0.pop_front();
                chk("d0_data", mat0, e.data);
                chk("d0_latency", 96'(cyc - e.start), 96'd6);
            end
        end
        prev0 = rdy0;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rdy1 && !prev1) begin
            if (q1.size() == 0) begin
                fail_note("d1_spurious_ready");
            end else begin
                e = q1.pop_front();
                chk("d1_data", 96'(mat1), e.data);
                chk("d1_latency", 96'(cyc - e.start), 96'd1);
            end
        end
        prev1 = rdy1;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rdy2 && !prev2) begin
            if (q2.size() == 0) begin
                fail_note("d2_spurious_ready");
            end else begin
                e = q2.pop_front();
                chk("d2_data", mat2, e.data);
                chk("d2_latency", 96'(cyc - e.start), 96'd12);
            end
        end
        prev2 = rdy2;
    end

    function automatic int qsize(input int sel);
        case (sel)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic wait_done(input int sel);
        for (int i = 0; i < 60; i++) begin
            if (qsize(sel) == 0) return;
            @(negedge clk);
        end
        fail_note($sformatf("timeout_dut%0d", sel));
        case (sel)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic go0(input logic [95:0] a, input logic [95:0] b,
                       input logic [95:0] exp);
        a0   = a;
        b0   = b;
        cmd0 = 1'b1;
        q0.push_back('{exp, cyc + 1});
    endtask

    localparam logic [95:0] A_T1 =
        {16'd2, 16'd1, 16'd3, 16'd3, 16'd1, 16'd0};
    localparam logic [95:0] E_T1 = 96'h0004_0002_0006_0006_0002_0000;
    localparam logic [95:0] A_WR = {6{16'hFFFF}};
    localparam logic [95:0] B_WR = {6{16'h0002}};
    localparam logic [95:0] E_WR = {6{16'h0001}};
    localparam logic [95:0] A_T3 =
        {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [95:0] B_T3 =
        96'h0060_0050_0040_0030_0020_0010;
    localparam logic [95:0] E_T3 =
        96'h0066_0055_0044_0033_0022_0011;

    initial begin
        logic [15:0] s1;
        logic [7:0]  x, y, s;
        logic [95:0] e2;
        checks = 0;
        errors = 0;
        prev0 = 1'b0;
        prev1 = 1'b0;
        prev2 = 1'b0;
        rst_n = 1'b0;
        cmd0 = 1'b0;
        cmd1 = 1'b0;
        cmd2 = 1'b0;
        a0 = '0; b0 = '0;
        a1 = '0; b1 = '0;
        a2 = '0; b2 = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 96'(rdy0), 96'd0);
        chk("rst_matrix", mat0, 96'd0);
        chk("rst_matrix_d2", mat2, 96'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum, command held high afterwards
        go0(A_T1, A_T1, E_T1);
        wait_done(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_ready", 96'(rdy0), 96'd1);
            chk("hold_matrix", mat0, E_T1);
        end
        cmd0 = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_ready", 96'(rdy0), 96'd0);
        chk("drop_matrix", mat0, E_T1);
        @(negedge clk);

        // Wrap-around, operands disturbed after being sampled
        go0(A_WR, B_WR, E_WR);
        @(negedge clk);
        a0 = {$urandom, $urandom, $urandom};
        b0 = {$urandom, $urandom, $urandom};
        wait_done(0);
        chk("wrap_ready", 96'(rdy0), 96'd1);
        cmd0 = 1'b0;
        @(negedge clk);
        chk("idle_retain", mat0, E_WR);

        // Reset while CALC is at element 3
        a0 = A_T3;
        b0 = B_T3;
        cmd0 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 96'(rdy0), 96'd0);
        chk("async_rst_matrix", mat0, 96'd0);
        cmd0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_ready", 96'(rdy0), 96'd0);
        chk("post_rst_matrix", mat0, 96'd0);

        // Fresh calculation after reset
        go0(A_T3, B_T3, E_T3);
        wait_done(0);
        cmd0 = 1'b0;
        @(negedge clk);

        // 1x1 sweep
        for (int r = 0; r < 3; r++) begin
            a1 = 16'($urandom);
            b1 = (r == 0) ? 16'hFFFF - a1 + 16'd1 : 16'($urandom);
            s1 = a1 + b1;
            cmd1 = 1'b1;
            q1.push_back('{96'(s1), cyc + 1});
            wait_done(1);
            cmd1 = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end

        // 4x3x8 sweep
        for (int r = 0; r < 2; r++) begin
            e2 = '0;
            for (int k = 0; k < 12; k++) begin
                x = 8'($urandom);
                y = (r == 0 && k == 0) ? 8'hFF : 8'($urandom);
                s = x + y;
                a2[k*8 +: 8] = x;
                b2[k*8 +: 8] = y;
                e2[k*8 +: 8] = s;
            end
            cmd2 = 1'b1;
            q2.push_back('{e2, cyc + 1});
            wait_done(2);
            cmd2 = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
